// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-sequencing memory controller: request sizes,
// FSM states and the size-to-byte-count helper.
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_SETUP   = 3'd2,
        ST_STROBE  = 3'd3,
        ST_WAIT    = 3'd4,
        ST_RELEASE = 3'd5,
        ST_DONE    = 3'd6,
        ST_FAIL    = 3'd7
    } state_t;

    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// 32-bit read assembly register with per-lane byte writes and a
// sign/zero-extension view sized to the active request.
module byte_assembler
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        we,
    input  logic [1:0]  lane,
    input  logic [7:0]  din,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] result
);

    logic [31:0] asm_q, asm_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        asm_d = asm_q;
        if (clr) begin
            asm_d = '0;
        end else if (we) begin
            asm_d[{lane, 3'b000} +: 8] = din;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            asm_q <= '0;
        end else begin
            asm_q <= asm_d;
        end
    end

    always_comb begin
        result = asm_q;
        case (size)
            SZ_BYTE: result = {{24{sign_ext & asm_q[7]}}, asm_q[7:0]};
            SZ_HALF: result = {{16{sign_ext & asm_q[15]}}, asm_q[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_byte_seq_ctrl.sv
// Splits byte/halfword/word requests into single-byte RAM handshakes and
// returns one done or err pulse per accepted request.
module mem_byte_seq_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int ADDR_W  = 9
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req,
    input  logic              rw,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic              ram_en,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout,
    input  logic              ram_moc
);

    // The count reaching TIMEOUT aborts, so the last tolerated value is TIMEOUT-1.
    localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

    state_t state_q, state_d;

    logic              rw_q, rw_d, sext_q, sext_d;
    logic [1:0]        size_q, size_d, k_q, k_d;
    logic [ADDR_W-1:0] addr_q, addr_d, ram_addr_q, ram_addr_d;
    logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              done_q, done_d, err_q, err_d, busy_q, busy_d;
    logic              ram_en_q, ram_en_d, ram_rw_q, ram_rw_d;
    logic [7:0]        ram_din_q, ram_din_d;

    logic        accept, moc_hit, illegal, more;
    logic [2:0]  n_bytes;
    logic [31:0] asm_result;

    assign accept  = (state_q == ST_IDLE) && req;
    assign moc_hit = (state_q == ST_WAIT) && ram_en_q && ram_moc;
    assign n_bytes = byte_count(size_q);
    assign illegal = (size_q == 2'b11)
                  || ((size_q == SZ_HALF) && addr_q[0])
                  || ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
    assign more    = ({1'b0, k_q} + 3'd1) < n_bytes;

    byte_assembler u_asm (
        .clk      (Clk),
        .reset    (Reset),
        .clr      (accept && rw),
        .we       (moc_hit && rw_q),
        .lane     (k_q),
        .din      (ram_dout),
        .size     (size_q),
        .sign_ext (sext_q),
        .result   (asm_result)
    );

    always_ff @(posedge Clk) begin : state_reg
        if (Reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (req) state_d = ST_CHECK;
            ST_CHECK:   state_d = illegal ? ST_FAIL : ST_SETUP;
            ST_SETUP:   state_d = ST_STROBE;
            ST_STROBE:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (moc_hit)                 state_d = ST_RELEASE;
                else if (cnt_q == TO_LAST)   state_d = ST_FAIL;
            end
            ST_RELEASE: state_d = more ? ST_SETUP : ST_DONE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin : datapath
        rw_d    = rw_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            rw_d    = rw;
            size_d  = size;
            sext_d  = sign_ext;
            addr_d  = addr;
            wdata_d = wdata;
        end
        k_d = k_q;
        if (state_q == ST_CHECK)                k_d = '0;
        else if (state_q == ST_RELEASE && more) k_d = k_q + 2'd1;
        cnt_d = cnt_q;
        if (state_q == ST_STROBE)                cnt_d = '0;
        else if (state_q == ST_WAIT && !moc_hit) cnt_d = cnt_q + 4'd1;
    end

    // Outputs are registered from the current state, so each pin lags its state by one cycle.
    always_comb begin : outputs
        ram_en_d   = (state_q == ST_STROBE) || (state_q == ST_WAIT);
        ram_rw_d   = ram_rw_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        if (state_q == ST_SETUP) begin
            ram_rw_d   = rw_q;
            ram_addr_d = addr_q + ADDR_W'(k_q);
            ram_din_d  = wdata_q[{k_q, 3'b000} +: 8];
        end
        done_d  = (state_q == ST_DONE);
        err_d   = (state_q == ST_FAIL);
        busy_d  = (state_q == ST_IDLE) ? req : !((state_q == ST_DONE) || (state_q == ST_FAIL));
        rdata_d = (state_q == ST_DONE && rw_q) ? asm_result : rdata_q;
    end

    always_ff @(posedge Clk) begin : regs
        if (Reset) begin
            rw_q       <= 1'b0;
            size_q     <= '0;
            sext_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            k_q        <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            ram_en_q   <= 1'b0;
            ram_rw_q   <= 1'b1;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else begin
            rw_q       <= rw_d;
            size_q     <= size_d;
            sext_q     <= sext_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            ram_en_q   <= ram_en_d;
            ram_rw_q   <= ram_rw_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
        end
    end

    assign rdata    = rdata_q;
    assign done     = done_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign ram_en   = ram_en_q;
    assign ram_rw   = ram_rw_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_mem_byte_seq_ctrl.sv
// Self-checking bench: behavioural RAM with programmable MOC delay, request
// model computing latency, write traffic and read results from the rules.
module tb_mem_byte_seq_ctrl;

    localparam int T  = 15;
    localparam int AW = 9;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          req = 1'b0, rw = 1'b0, sign_ext = 1'b0;
    logic [1:0]    size = 2'b00;
    logic [AW-1:0] addr = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          done, err, busy, ram_en, ram_rw, ram_moc;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din, ram_dout;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rdata = '0;

    mem_byte_seq_ctrl #(.TIMEOUT(T), .ADDR_W(AW)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .rw(rw), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy),
        .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .ram_moc(ram_moc)
    );

    always #5 Clk = ~Clk;

    // Behavioural RAM: one MOC per Enable, after moc_delay extra cycles.
    typedef struct packed { logic [AW-1:0] a; logic [7:0] d; } wr_t;
    logic [7:0] mem [512];
    wr_t  wlog[$];
    int   moc_delay = 0;
    int   block_addr = -1;
    int   en_cnt = 0;
    logic served = 1'b0;

    assign ram_dout = mem[ram_addr];
    assign ram_moc  = ram_en && (en_cnt >= moc_delay) && !served && (int'(ram_addr) != block_addr);

    always @(posedge Clk) begin
        if (!ram_en) begin
            en_cnt <= 0;
            served <= 1'b0;
        end else begin
            en_cnt <= en_cnt + 1;
            if (ram_moc) served <= 1'b1;
        end
        if (ram_en && ram_moc && !ram_rw) begin
            mem[ram_addr] <= ram_din;
            wlog.push_back({ram_addr, ram_din});
        end
    end

    // ---------------- reference model ----------------
    function automatic bit legal(input logic [1:0] sz, input logic [AW-1:0] a);
        if (sz == 2'b11) return 1'b0;
        if (sz == 2'b01 && a[0]) return 1'b0;
        if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic logic [31:0] exp_read(input logic [AW-1:0] a, input logic [1:0] sz, input logic se);
        int n;
        logic [31:0] v;
        n = nbytes(sz);
        v = '0;
        for (int k = 0; k < n; k++) v = v | (32'(mem[AW'(a + k)]) << (8 * k));
        if (se && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic int write_mismatches(input int base, input logic [AW-1:0] a, input int n,
                                            input logic [31:0] wd);
        int bad;
        wr_t e;
        bad = 0;
        if (wlog.size() - base != n) return 1 + n;
        for (int k = 0; k < n; k++) begin
            e = wlog[base + k];
            if (e.a !== AW'(a + k) || e.d !== wd[8 * k +: 8]) bad++;
        end
        return bad;
    endfunction

    // Issues one request and observes it; returns latency (-1 if it never ended).
    task automatic run_req(input logic rw_i, input logic [1:0] sz, input logic [AW-1:0] a,
                           input logic [31:0] wd, input logic se,
                           output int lat, output bit got_done, output bit got_err,
                           output int rises, output int proto_bad);
        logic p_en, p_rw;
        logic [AW-1:0] p_addr;
        logic [7:0] p_din;
        lat = -1; got_done = 0; got_err = 0; rises = 0; proto_bad = 0;
        @(negedge Clk);
        req = 1'b1; rw = rw_i; size = sz; addr = a; wdata = wd; sign_ext = se;
        @(posedge Clk); #1;
        req = 1'b0; rw = 1'($urandom); size = 2'($urandom); addr = AW'($urandom);
        wdata = $urandom; sign_ext = 1'($urandom);
        p_en = ram_en; p_rw = ram_rw; p_addr = ram_addr; p_din = ram_din;
        for (int c = 1; c <= 400; c++) begin
            @(posedge Clk); #1;
            if (ram_en !== p_en) begin
                if (ram_en) rises++;
                if (ram_addr !== p_addr || ram_rw !== p_rw || ram_din !== p_din) proto_bad++;
            end
            p_en = ram_en; p_rw = ram_rw; p_addr = ram_addr; p_din = ram_din;
            if (done && err) proto_bad++;
            if (done || err) begin
                if (busy !== 1'b0) proto_bad++;
                lat = c; got_done = done; got_err = err;
                break;
            end
            if (busy !== 1'b1) proto_bad++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 00000000", rdata); end
        checks++;
        if ({done, err, busy, ram_en} !== 4'b0000)
            begin errors++; $display("FAIL reset_ctrl: done/err/busy/en=%b want 0000", {done, err, busy, ram_en}); end
        checks++;
        if (ram_rw !== 1'b1 || ram_addr !== '0 || ram_din !== 8'h00)
            begin errors++; $display("FAIL reset_bus: rw=%b addr=%h din=%h want 1 000 00", ram_rw, ram_addr, ram_din); end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_word_write();
        int lat, rises, pb, base;
        bit d, e;
        moc_delay = 0;
        base = wlog.size();
        run_req(1'b0, 2'b10, 9'h010, 32'hDEADBEEF, 1'b0, lat, d, e, rises, pb);
        checks++;
        if (lat !== 18 || d !== 1'b1 || e !== 1'b0)
            begin errors++; $display("FAIL word_write_latency: got %0d done=%0b err=%0b want 18 1 0", lat, d, e); end
        checks++;
        if (write_mismatches(base, 9'h010, 4, 32'hDEADBEEF) !== 0)
            begin errors++; $display("FAIL word_write_bytes: got %0d writes want EF BE AD DE at 010..013", wlog.size() - base); end
        checks++;
        if (rises !== 4 || pb !== 0) begin errors++; $display("FAIL word_write_proto: rises=%0d bad=%0d want 4 0", rises, pb); end
        checks++;
        if (rdata !== exp_rdata) begin errors++; $display("FAIL word_write_rdata: got %h want %h", rdata, exp_rdata); end
    endtask

    task automatic test_signed_byte_read();
        int lat, rises, pb;
        bit d, e;
        mem[5] = 8'h80;
        for (int s = 1; s >= 0; s--) begin
            exp_rdata = exp_read(9'h005, 2'b00, 1'(s));
            run_req(1'b1, 2'b00, 9'h005, $urandom, 1'(s), lat, d, e, rises, pb);
            checks++;
            if (lat !== 6 || d !== 1'b1 || e !== 1'b0 || pb !== 0 || rises !== 1)
                begin errors++; $display("FAIL byte_read_timing s=%0d: lat=%0d done=%0b err=%0b bad=%0d rises=%0d want 6 1 0 0 1", s, lat, d, e, pb, rises); end
            checks++;
            if (rdata !== exp_rdata) begin errors++; $display("FAIL byte_read_rdata s=%0d: got %h want %h", s, rdata, exp_rdata); end
        end
    endtask

    task automatic test_illegal();
        int lat, rises, pb;
        bit d, e;
        logic [1:0] szs [3] = '{2'b01, 2'b10, 2'b11};
        logic [AW-1:0] as [3] = '{9'h003, 9'h006, 9'h008};
        for (int i = 0; i < 3; i++) begin
            run_req(1'b1, szs[i], as[i], $urandom, 1'b1, lat, d, e, rises, pb);
            checks++;
            if (lat !== 2 || e !== 1'b1 || d !== 1'b0 || pb !== 0)
                begin errors++; $display("FAIL illegal_%0d: lat=%0d err=%0b done=%0b bad=%0d want 2 1 0 0", i, lat, e, d, pb); end
            checks++;
            if (rises !== 0 || rdata !== exp_rdata)
                begin errors++; $display("FAIL illegal_%0d_side: rises=%0d rdata=%h want 0 %h", i, rises, rdata, exp_rdata); end
        end
    endtask

    task automatic test_timeout();
        int lat, rises, pb;
        bit d, e;
        block_addr = 'h041;
        run_req(1'b1, 2'b01, 9'h040, $urandom, 1'b0, lat, d, e, rises, pb);
        checks++;
        if (lat !== 4 + 4 + T || e !== 1'b1 || d !== 1'b0)
            begin errors++; $display("FAIL timeout_latency: lat=%0d err=%0b done=%0b want %0d 1 0", lat, e, d, 8 + T); end
        checks++;
        if (ram_en !== 1'b0 || rises !== 2 || pb !== 0)
            begin errors++; $display("FAIL timeout_bus: en=%b rises=%0d bad=%0d want 0 2 0", ram_en, rises, pb); end
        checks++;
        if (rdata !== exp_rdata) begin errors++; $display("FAIL timeout_rdata: got %h want %h", rdata, exp_rdata); end
        block_addr = -1;
    endtask

    task automatic test_stretched_moc();
        int lat, rises, pb;
        bit d, e;
        mem['h020] = 8'h78; mem['h021] = 8'h56; mem['h022] = 8'h34; mem['h023] = 8'h12;
        moc_delay = 3;
        exp_rdata = exp_read(9'h020, 2'b10, 1'b1);
        run_req(1'b1, 2'b10, 9'h020, $urandom, 1'b1, lat, d, e, rises, pb);
        checks++;
        if (lat !== 30 || d !== 1'b1 || e !== 1'b0)
            begin errors++; $display("FAIL stretched_latency: lat=%0d done=%0b err=%0b want 30 1 0", lat, d, e); end
        checks++;
        if (rdata !== exp_rdata || rdata !== 32'h12345678)
            begin errors++; $display("FAIL stretched_rdata: got %h want 12345678", rdata); end
        checks++;
        if (rises !== 4 || pb !== 0) begin errors++; $display("FAIL stretched_proto: rises=%0d bad=%0d want 4 0", rises, pb); end
        moc_delay = 0;
    endtask

    task automatic test_reset_midway();
        int lat, rises, pb, base, quiet_bad;
        bit d, e, seen;
        base = wlog.size();
        @(negedge Clk);
        req = 1'b1; rw = 1'b0; size = 2'b10; addr = 9'h100; wdata = 32'hA1B2C3D4; sign_ext = 1'b0;
        @(posedge Clk); #1;
        req = 1'b0;
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            if (wlog.size() - base >= 2) begin seen = 1; break; end
            @(posedge Clk); #1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL midreset_progress: got %0d writes want 2", wlog.size() - base); end
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        exp_rdata = '0;
        checks++;
        if ({ram_en, busy, done, err} !== 4'b0000 || rdata !== exp_rdata)
            begin errors++; $display("FAIL midreset_state: en/busy/done/err=%b rdata=%h want 0000 0", {ram_en, busy, done, err}, rdata); end
        quiet_bad = 0;
        repeat (20) begin
            @(posedge Clk); #1;
            if (done || err || ram_en || busy) quiet_bad++;
        end
        checks++;
        if (quiet_bad !== 0) begin errors++; $display("FAIL midreset_quiet: got %0d active cycles want 0", quiet_bad); end
        checks++;
        if (write_mismatches(base, 9'h100, 2, 32'hA1B2C3D4) !== 0)
            begin errors++; $display("FAIL midreset_writes: got %0d writes want D4@100 C3@101 only", wlog.size() - base); end
        exp_rdata = exp_read(9'h101, 2'b00, 1'b1);
        run_req(1'b1, 2'b00, 9'h101, $urandom, 1'b1, lat, d, e, rises, pb);
        checks++;
        if (lat !== 6 || d !== 1'b1 || rdata !== exp_rdata || rdata !== 32'hFFFFFFC3)
            begin errors++; $display("FAIL midreset_read: lat=%0d done=%0b rdata=%h want 6 1 ffffffc3", lat, d, rdata); end
    endtask

    task automatic test_random();
        int lat, rises, pb, base, n, exp_lat, wr_n;
        bit d, e, ok;
        logic r, se;
        logic [1:0] sz;
        logic [AW-1:0] a;
        logic [31:0] wd, exp_v;
        for (int i = 0; i < 40; i++) begin
            r  = 1'($urandom);
            sz = 2'($urandom_range(0, 3));
            a  = AW'($urandom);
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            wd = $urandom;
            se = 1'($urandom);
            moc_delay = $urandom_range(0, 2);
            ok = legal(sz, a);
            n  = ok ? nbytes(sz) : 0;
            exp_v = (r && ok) ? exp_read(a, sz, se) : exp_rdata;
            exp_lat = ok ? 2 + n * (4 + moc_delay) : 2;
            wr_n = (!r && ok) ? n : 0;
            base = wlog.size();
            run_req(r, sz, a, wd, se, lat, d, e, rises, pb);
            checks++;
            if (lat !== exp_lat || d !== ok || e !== !ok)
                begin errors++; $display("FAIL rand%0d_end: lat=%0d done=%0b err=%0b want %0d %0b %0b", i, lat, d, e, exp_lat, ok, !ok); end
            checks++;
            if (rises !== n || pb !== 0)
                begin errors++; $display("FAIL rand%0d_proto: rises=%0d bad=%0d want %0d 0", i, rises, pb, n); end
            checks++;
            if (write_mismatches(base, a, wr_n, wd) !== 0)
                begin errors++; $display("FAIL rand%0d_writes: got %0d want %0d at %h", i, wlog.size() - base, wr_n, a); end
            exp_rdata = exp_v;
            checks++;
            if (rdata !== exp_rdata) begin errors++; $display("FAIL rand%0d_rdata: got %h want %h", i, rdata, exp_rdata); end
        end
        moc_delay = 0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        test_reset();
        test_word_write();
        test_signed_byte_read();
        test_illegal();
        test_timeout();
        test_stretched_moc();
        test_reset_midway();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
